// File: rtl/slicel_gen2_if.sv
// Signal bundle of the slicel_gen2 logic slice: user datapath, config scan chain and outputs.
interface slicel_gen2_if #(
  parameter int unsigned S_XX_BASE = 4,
  parameter int unsigned NUM_LUTS  = 4
);
  localparam int unsigned MuxLvls = $clog2(NUM_LUTS);

  logic [2*S_XX_BASE*NUM_LUTS-1:0] luts_in;
  logic [MuxLvls-1:0]              higher_order_addr;
  logic                            Ci;
  logic                            reg_ce;
  logic                            reg_srst;
  logic                            cfg_shift_en;
  logic                            cfg_bit_in;
  logic                            cfg_commit;
  logic                            cfg_bit_out;
  logic                            cfg_full;
  logic                            cfg_valid;
  logic                            cfg_err;
  logic                            Co;
  logic [2*NUM_LUTS-1:0]           out;
  logic [2*NUM_LUTS-1:0]           sync_out;

  modport master (
    output luts_in, higher_order_addr, Ci, reg_ce, reg_srst, cfg_shift_en, cfg_bit_in,
           cfg_commit,
    input  cfg_bit_out, cfg_full, cfg_valid, cfg_err, Co, out, sync_out
  );

  modport slave (
    input  luts_in, higher_order_addr, Ci, reg_ce, reg_srst, cfg_shift_en, cfg_bit_in,
           cfg_commit,
    output cfg_bit_out, cfg_full, cfg_valid, cfg_err, Co, out, sync_out
  );
endinterface

// File: rtl/slicel_gen2.sv
// Logic slice: fracturable dual-output LUTs, F-mux tree, ripple carry and output FFs, configured
// through a shadowed serial scan chain that only takes effect on commit.
module slicel_gen2 #(
  parameter int unsigned S_XX_BASE = 4,
  parameter int unsigned NUM_LUTS  = 4
) (
  input logic          clk,
  input logic          rst_n,
  slicel_gen2_if.slave bus
);
  localparam int unsigned LutW     = 2**S_XX_BASE;
  localparam int unsigned CfgLut   = 2*LutW + 1;
  localparam int unsigned MuxLvls  = $clog2(NUM_LUTS);
  localparam int unsigned NumOut   = 2*NUM_LUTS;
  localparam int unsigned InitLsb  = NUM_LUTS*CfgLut;
  localparam int unsigned UseCcBit = InitLsb + NumOut;
  localparam int unsigned MuxLsb   = UseCcBit + 1;
  localparam int unsigned CfgTotal = MuxLsb + MuxLvls;
  localparam int unsigned CntW     = $clog2(CfgTotal + 1);

  typedef enum logic {StUncfg, StRun} state_e;

  state_e                state_q, state_d;
  logic [CfgTotal-1:0]   shadow_q, shadow_d;
  logic [CfgTotal-1:0]   active_q, active_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  err_q, err_d;
  logic [NumOut-1:0]     sync_q, sync_d;
  logic                  full, commit_ok, run;

  logic [NUM_LUTS-1:0]   c0, g, m, s;
  logic [NUM_LUTS:0]     c;
  logic [NumOut-1:0]     out_w;
  logic                  use_cc;
  logic [MuxLvls-1:0]    mux_lvl, sel_mask;
  int unsigned           k;

  assign full      = (count_q == CntW'(CfgTotal));
  assign commit_ok = bus.cfg_commit & full;
  assign run       = (state_q == StRun);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    err_d    = err_q | (bus.cfg_commit & ~full);
    if (bus.cfg_shift_en) begin
      shadow_d = {bus.cfg_bit_in, shadow_q[CfgTotal-1:1]};
      if (!full) count_d = count_q + CntW'(1);
    end
    // Commit captures the pre-edge shadow; a shift in the same cycle starts the next load.
    if (commit_ok) begin
      state_d  = StRun;
      active_d = shadow_q;
      count_d  = CntW'(bus.cfg_shift_en);
    end
  end

  always_comb begin
    sync_d = sync_q;
    if (commit_ok) begin
      sync_d = shadow_q[InitLsb +: NumOut];
    end else if (run) begin
      if (bus.reg_srst)    sync_d = active_q[InitLsb +: NumOut];
      else if (bus.reg_ce) sync_d = out_w;
    end
  end

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    logic [S_XX_BASE-1:0] lo, hi;
    logic [LutW-1:0]      f0, f1;
    logic                 split;
    assign lo    = bus.luts_in[2*S_XX_BASE*i +: S_XX_BASE];
    assign hi    = bus.luts_in[2*S_XX_BASE*i+S_XX_BASE +: S_XX_BASE];
    assign f0    = active_q[CfgLut*i +: LutW];
    assign f1    = active_q[CfgLut*i+LutW +: LutW];
    assign split = active_q[CfgLut*i+2*LutW];
    // Unsplit: hi[0] widens the low function to S+1 inputs using F1 as the upper half.
    assign c0[i] = (split || !hi[0]) ? f0[lo] : f1[lo];
    assign g[i]  = f1[hi];
  end

  always_comb begin
    use_cc   = active_q[UseCcBit];
    mux_lvl  = active_q[MuxLsb +: MuxLvls];
    k        = (32'(mux_lvl) > MuxLvls) ? MuxLvls : 32'(mux_lvl);
    sel_mask = MuxLvls'((32'd1 << k) - 32'd1);
    m        = '0;
    s        = '0;
    c        = '0;
    out_w    = '0;
    c[0]     = bus.Ci;
    for (int unsigned i = 0; i < NUM_LUTS; i++) begin
      m[i]           = c0[(MuxLvls'(i) & ~sel_mask) | (bus.higher_order_addr & sel_mask)];
      c[i+1]         = g[i] | (c0[i] & c[i]);
      s[i]           = c0[i] ^ c[i];
      out_w[2*i]     = use_cc ? s[i] : m[i];
      out_w[2*i+1]   = g[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StUncfg;
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      err_q    <= err_d;
      sync_q   <= sync_d;
    end
  end

  assign bus.out         = run ? out_w : '0;
  assign bus.Co          = run & c[NUM_LUTS];
  assign bus.sync_out    = sync_q;
  assign bus.cfg_valid   = run;
  assign bus.cfg_full    = full;
  assign bus.cfg_err     = err_q;
  assign bus.cfg_bit_out = shadow_q[0];
endmodule

// File: tb/tb_slicel_gen2.sv
// Scoreboard bench for slicel_gen2: expectations are queued as stimulus is applied and compared
// against the DUT outputs at the next sampling point.
module tb_slicel_gen2;
  localparam int unsigned CfgTotal = 143;

  typedef enum int {ObsOut, ObsSync, ObsCo, ObsValid, ObsFull, ObsErr, ObsBitOut} obs_e;
  typedef struct {
    string       tag;
    obs_e        obs;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  logic [CfgTotal-1:0] cfg_a, cfg_b, cfg_c, cfg_d;

  slicel_gen2_if #(.S_XX_BASE(4), .NUM_LUTS(4)) bus ();

  slicel_gen2 #(.S_XX_BASE(4), .NUM_LUTS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input obs_e obs, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.obs = obs;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [31:0] got;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.obs)
        ObsOut:    got = 32'(bus.out);
        ObsSync:   got = 32'(bus.sync_out);
        ObsCo:     got = 32'(bus.Co);
        ObsValid:  got = 32'(bus.cfg_valid);
        ObsFull:   got = 32'(bus.cfg_full);
        ObsErr:    got = 32'(bus.cfg_err);
        default:   got = 32'(bus.cfg_bit_out);
      endcase
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_cfg(input logic [CfgTotal-1:0] c, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.cfg_shift_en = 1'b1;
      bus.cfg_bit_in   = c[i];
      tick();
    end
    bus.cfg_shift_en = 1'b0;
    bus.cfg_bit_in   = 1'b0;
  endtask

  task automatic do_commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  function automatic logic [CfgTotal-1:0] mk_cfg(input logic [63:0] f0s, input logic [63:0] f1s,
                                                 input logic [3:0] split, input logic [7:0] init,
                                                 input logic use_cc, input logic [1:0] mux_lvl);
    logic [CfgTotal-1:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[33*i +: 16]    = f0s[16*i +: 16];
      c[33*i+16 +: 16] = f1s[16*i +: 16];
      c[33*i+32]       = split[i];
    end
    c[132 +: 8] = init;
    c[140]      = use_cc;
    c[141 +: 2] = mux_lvl;
    return c;
  endfunction

  // Operand bit i goes to both halves of LUT i as {b_i, a_i}.
  function automatic logic [31:0] add_in(input logic [3:0] a, input logic [3:0] b);
    logic [31:0] r;
    logic [3:0]  lo;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      lo           = {2'b00, b[i], a[i]};
      r[8*i +: 8]  = {lo, lo};
    end
    return r;
  endfunction

  function automatic logic [7:0] add_exp(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
    logic [4:0] sum;
    logic [7:0] e;
    sum = 5'(a) + 5'(b) + 5'(ci);
    for (int i = 0; i < 4; i++) begin
      e[2*i]   = sum[i];
      e[2*i+1] = a[i] & b[i];
    end
    return e;
  endfunction

  initial begin
    logic [3:0] va, vb;
    logic       vc;
    logic [4:0] vsum;
    n_checks = 0;
    n_fail   = 0;
    cfg_a = mk_cfg(64'h0000_0000_0000_8000, 64'h0, 4'hF, 8'h00, 1'b0, 2'd0);
    cfg_b = mk_cfg(64'h6666_6666_6666_6666, 64'h8888_8888_8888_8888, 4'hF, 8'hA5, 1'b1, 2'd0);
    cfg_c = mk_cfg(64'h0000_FFFF_0000_0000, 64'h0, 4'hF, 8'h00, 1'b0, 2'd2);
    cfg_d = mk_cfg(64'h0000_FFFF_0000_0000, 64'h0000_0000_0000_0001, 4'b1110, 8'h3C, 1'b0,
                   2'd3);

    rst_n = 1'b0;
    bus.luts_in = '0;
    bus.higher_order_addr = '0;
    bus.Ci = 1'b0;
    bus.reg_ce = 1'b0;
    bus.reg_srst = 1'b0;
    bus.cfg_shift_en = 1'b0;
    bus.cfg_bit_in = 1'b0;
    bus.cfg_commit = 1'b0;
    #2;
    sb_push("rst_out", ObsOut, 32'h0);
    sb_push("rst_sync", ObsSync, 32'h0);
    sb_push("rst_co", ObsCo, 32'h0);
    sb_push("rst_valid", ObsValid, 32'h0);
    sb_push("rst_full", ObsFull, 32'h0);
    sb_push("rst_err", ObsErr, 32'h0);
    sb_check();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset mid-shift.
    shift_cfg(cfg_a, 0, 69);
    rst_n = 1'b0;
    sb_push("midrst_full", ObsFull, 32'h0);
    sb_push("midrst_valid", ObsValid, 32'h0);
    sb_push("midrst_out", ObsOut, 32'h0);
    sb_push("midrst_sync", ObsSync, 32'h0);
    sb_push("midrst_bitout", ObsBitOut, 32'h0);
    sb_check();
    tick();
    rst_n = 1'b1;

    // Short load then commit is refused; the completing bit allows a real commit.
    shift_cfg(cfg_a, 0, 141);
    sb_push("short_full", ObsFull, 32'h0);
    sb_check();
    do_commit();
    sb_push("short_err", ObsErr, 32'h1);
    sb_push("short_valid", ObsValid, 32'h0);
    sb_push("short_full2", ObsFull, 32'h0);
    sb_check();
    shift_cfg(cfg_a, 142, 142);
    sb_push("load_full", ObsFull, 32'h1);
    sb_check();
    bus.cfg_commit = 1'b1;
    sb_push("pre_commit_valid", ObsValid, 32'h0);
    sb_check();
    tick();
    bus.cfg_commit = 1'b0;
    sb_push("commit_valid", ObsValid, 32'h1);
    sb_push("commit_err_sticky", ObsErr, 32'h1);
    sb_push("commit_full_clr", ObsFull, 32'h0);
    sb_push("commit_sync", ObsSync, 32'h0);
    sb_check();
    bus.luts_in = 32'h0000_000F;
    sb_push("and4_hit", ObsOut, 32'h01);
    sb_push("and4_co", ObsCo, 32'h0);
    sb_check();
    bus.luts_in = 32'h0000_000E;
    sb_push("and4_miss", ObsOut, 32'h00);
    sb_check();

    // Carry-chain adder with FF init A5.
    shift_cfg(cfg_b, 0, CfgTotal - 1);
    do_commit();
    sb_push("add_sync_init", ObsSync, 32'hA5);
    sb_check();
    for (int t = 0; t < 9; t++) begin
      case (t)
        0:       begin va = 4'h7; vb = 4'h9; vc = 1'b0; end
        1:       begin va = 4'h7; vb = 4'h9; vc = 1'b1; end
        2:       begin va = 4'h3; vb = 4'h4; vc = 1'b0; end
        3:       begin va = 4'hF; vb = 4'hF; vc = 1'b1; end
        4:       begin va = 4'h0; vb = 4'h0; vc = 1'b1; end
        default: begin
          va = 4'($urandom_range(0, 15));
          vb = 4'($urandom_range(0, 15));
          vc = 1'($urandom_range(0, 1));
        end
      endcase
      bus.luts_in = add_in(va, vb);
      bus.Ci = vc;
      vsum = 5'(va) + 5'(vb) + 5'(vc);
      sb_push($sformatf("add_%0h_%0h_%0b_out", va, vb, vc), ObsOut, 32'(add_exp(va, vb, vc)));
      sb_push($sformatf("add_%0h_%0h_%0b_co", va, vb, vc), ObsCo, 32'(vsum[4]));
      sb_check();
    end

    bus.luts_in = add_in(4'h7, 4'h9);
    bus.Ci = 1'b0;
    bus.reg_ce = 1'b1;
    tick();
    sb_push("ff_ce_capture", ObsSync, 32'h02);
    sb_check();
    bus.reg_srst = 1'b1;
    tick();
    sb_push("ff_srst_over_ce", ObsSync, 32'hA5);
    sb_check();
    bus.reg_srst = 1'b0;
    bus.reg_ce = 1'b0;
    bus.luts_in = add_in(4'h3, 4'h4);
    tick();
    sb_push("ff_hold", ObsSync, 32'hA5);
    sb_check();

    // Stage the F-mux config while the adder keeps running.
    shift_cfg(cfg_c, 0, 49);
    sb_push("stage_out_a", ObsOut, 32'h15);
    sb_check();
    shift_cfg(cfg_c, 50, 99);
    sb_push("stage_out_b", ObsOut, 32'h15);
    sb_check();
    shift_cfg(cfg_c, 100, CfgTotal - 1);
    bus.higher_order_addr = 2'd2;
    sb_push("stage_out_c", ObsOut, 32'h15);
    sb_push("stage_full", ObsFull, 32'h1);
    sb_push("stage_bitout", ObsBitOut, 32'(cfg_c[0]));
    sb_check();
    bus.cfg_commit = 1'b1;
    sb_push("stage_pre_edge", ObsOut, 32'h15);
    sb_check();
    tick();
    bus.cfg_commit = 1'b0;
    sb_push("fmux_hoa2", ObsOut, 32'h55);
    sb_push("fmux_sync", ObsSync, 32'h00);
    sb_check();
    bus.higher_order_addr = 2'd1;
    sb_push("fmux_hoa1", ObsOut, 32'h00);
    sb_check();

    // Overfull load (one leading dummy bit), clamped mux_lvl, LUT0 unsplit.
    shift_cfg(~cfg_d, 0, 0);
    shift_cfg(cfg_d, 0, CfgTotal - 1);
    sb_push("sat_full", ObsFull, 32'h1);
    sb_push("sat_bitout", ObsBitOut, 32'(cfg_d[0]));
    sb_check();
    do_commit();
    sb_push("clamp_sync", ObsSync, 32'h3C);
    sb_check();
    bus.higher_order_addr = 2'd2;
    bus.luts_in = 32'h0000_0000;
    sb_push("clamp_hoa2", ObsOut, 32'h57);
    sb_check();
    bus.higher_order_addr = 2'd0;
    bus.luts_in = 32'h0000_0010;
    sb_push("unsplit_hi1_lo0", ObsOut, 32'h55);
    sb_check();
    bus.luts_in = 32'h0000_0000;
    sb_push("unsplit_hi0_lo0", ObsOut, 32'h02);
    sb_check();
    bus.luts_in = 32'h0000_0011;
    sb_push("unsplit_hi1_lo1", ObsOut, 32'h00);
    sb_check();

    // Reset while running.
    bus.higher_order_addr = 2'd2;
    bus.luts_in = 32'h0000_0000;
    rst_n = 1'b0;
    sb_push("runrst_out", ObsOut, 32'h0);
    sb_push("runrst_co", ObsCo, 32'h0);
    sb_push("runrst_valid", ObsValid, 32'h0);
    sb_push("runrst_sync", ObsSync, 32'h0);
    sb_push("runrst_err", ObsErr, 32'h0);
    sb_check();
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
